// File: rtl/child_response_collector_if.sv
// rtl/child_response_collector_if.sv - child-side and upstream handshake bundle for the response collector
interface child_response_collector_if #(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 8
);
  localparam int SRC_W = $clog2(NUM_CHILDREN);

  logic [NUM_CHILDREN-1:0]        in_valid;
  logic [NUM_CHILDREN*DATA_W-1:0] in_data;
  logic [NUM_CHILDREN-1:0]        in_ready;
  logic                           out_valid;
  logic [DATA_W-1:0]              out_data;
  logic [SRC_W-1:0]               out_src;
  logic                           out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/child_response_collector.sv
// rtl/child_response_collector.sv - round-robin N-to-1 fan-in of child responses, source-tagged, one output register
// Optional transfer counter port word_count enabled by CHILD_RESPONSE_COLLECTOR_COUNT_EN.
module child_response_collector #(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef CHILD_RESPONSE_COLLECTOR_COUNT_EN
  output logic [15:0]                 word_count,
`endif
  child_response_collector_if.slave   bus
);
  localparam int SRC_W = $clog2(NUM_CHILDREN);
  localparam logic [SRC_W-1:0] LAST_CHILD = SRC_W'(NUM_CHILDREN - 1);

  logic [SRC_W-1:0]        rr_ptr;
  logic [SRC_W-1:0]        grant;
  logic [SRC_W-1:0]        cand;
  logic                    found;
  logic                    any_valid;
  logic                    load_ok;
  logic                    child_xfer;
  logic [NUM_CHILDREN-1:0] ready_vec;
  logic [DATA_W-1:0]       words [NUM_CHILDREN];

  logic                    out_valid_q;
  logic [DATA_W-1:0]       out_data_q;
  logic [SRC_W-1:0]        out_src_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHILDREN; gi++) begin : g_words
      assign words[gi] = bus.in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Walk children starting one past the last winner, wrapping at NUM_CHILDREN.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = rr_ptr;
    for (int k = 0; k < NUM_CHILDREN; k++) begin
      cand = (cand == LAST_CHILD) ? '0 : cand + 1'b1;
      if (!found && bus.in_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign any_valid  = |bus.in_valid;
  assign load_ok    = !out_valid_q || bus.out_ready;
  assign ready_vec  = (!rst && load_ok && any_valid) ? (NUM_CHILDREN'(1) << grant) : '0;
  assign child_xfer = |(bus.in_valid & ready_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr      <= LAST_CHILD;
    end else if (child_xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= words[grant];
      out_src_q   <= grant;
      rr_ptr      <= grant;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef CHILD_RESPONSE_COLLECTOR_COUNT_EN
  logic [15:0] word_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count_q <= '0;
    end else if (child_xfer && word_count_q != 16'hFFFF) begin
      word_count_q <= word_count_q + 16'd1;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_child_response_collector.sv
// tb/tb_child_response_collector.sv - directed self-checking bench for child_response_collector
module tb_child_response_collector;
  localparam int N  = 5;
  localparam int DW = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

`ifdef CHILD_RESPONSE_COLLECTOR_COUNT_EN
  logic [15:0] word_count;
`endif

  child_response_collector_if #(.NUM_CHILDREN(N), .DATA_W(DW)) bus ();

  child_response_collector #(.NUM_CHILDREN(N), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CHILD_RESPONSE_COLLECTOR_COUNT_EN
    .word_count (word_count),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern_data();
    for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = 8'h10 + 8'(i);
  endtask

  task automatic do_reset();
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    set_pattern_data();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 5'b11111;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    checks++;
    if (bus.out_src !== 3'd0) begin failures++; $display("FAIL reset_out_src got=%0d exp=0", bus.out_src); end
    checks++;
    if (bus.in_ready !== 5'b00000) begin failures++; $display("FAIL reset_in_ready got=%b exp=00000", bus.in_ready); end
    bus.in_valid = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    bus.in_valid = 5'b00100;
    bus.in_data[2*DW +: DW] = 8'hA5;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 5'b00100) begin failures++; $display("FAIL single_in_ready got=%b exp=00100", bus.in_ready); end
    step();
    bus.in_valid = '0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_src !== 3'd2) begin
      failures++;
      $display("FAIL single_out got=v%b d%h s%0d exp=v1 dA5 s2", bus.out_valid, bus.out_data, bus.out_src);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_ready;
    do_reset();
    bus.in_valid  = 5'b11111;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      exp_ready = 5'b00001 << (c % N);
      #1;
      checks++;
      if (bus.in_ready !== exp_ready) begin
        failures++;
        $display("FAIL rr_in_ready cycle=%0d got=%b exp=%b", c, bus.in_ready, exp_ready);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_src !== 3'(c % N) || bus.out_data !== 8'h10 + 8'(c % N)) begin
        failures++;
        $display("FAIL rr_out cycle=%0d got=v%b s%0d d%h exp=v1 s%0d d%h",
                 c, bus.out_valid, bus.out_src, bus.out_data, c % N, 8'h10 + 8'(c % N));
      end
    end
    bus.in_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.in_valid = 5'b00010;
    bus.in_data[1*DW +: DW] = 8'h3C;
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.out_src !== 3'd1) begin
      failures++;
      $display("FAIL bp_load got=v%b d%h s%0d exp=v1 d3C s1", bus.out_valid, bus.out_data, bus.out_src);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 5'b11111;
    set_pattern_data();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (bus.in_ready !== 5'b00000) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=00000", c, bus.in_ready); end
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.out_src !== 3'd1) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got=v%b d%h s%0d exp=v1 d3C s1", c, bus.out_valid, bus.out_data, bus.out_src);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 5'b00100) begin failures++; $display("FAIL bp_release_ready got=%b exp=00100", bus.in_ready); end
    step();
    checks++;
    if (bus.out_src !== 3'd2 || bus.out_data !== 8'h12) begin
      failures++;
      $display("FAIL bp_release_out got=s%0d d%h exp=s2 d12", bus.out_src, bus.out_data);
    end
    bus.in_valid = '0;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.in_valid  = 5'b10000;
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_src !== 3'd4) begin failures++; $display("FAIL wrap_prime got=%0d exp=4", bus.out_src); end
    bus.in_valid = 5'b10001;
    #1;
    checks++;
    if (bus.in_ready !== 5'b00001) begin failures++; $display("FAIL wrap_first got=%b exp=00001", bus.in_ready); end
    step();
    checks++;
    if (bus.out_src !== 3'd0) begin failures++; $display("FAIL wrap_src0 got=%0d exp=0", bus.out_src); end
    #1;
    checks++;
    if (bus.in_ready !== 5'b10000) begin failures++; $display("FAIL wrap_second got=%b exp=10000", bus.in_ready); end
    step();
    checks++;
    if (bus.out_src !== 3'd4) begin failures++; $display("FAIL wrap_src4 got=%0d exp=4", bus.out_src); end
    bus.in_valid = '0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.in_valid  = 5'b01000;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== 3'd3) begin
      failures++;
      $display("FAIL areset_load got=v%b s%0d exp=v1 s3", bus.out_valid, bus.out_src);
    end
    #2;
    rst = 1'b1;
    bus.in_valid = 5'b11111;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL areset_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 5'b00000) begin failures++; $display("FAIL areset_in_ready got=%b exp=00000", bus.in_ready); end
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 5'b00001) begin failures++; $display("FAIL areset_first_grant got=%b exp=00001", bus.in_ready); end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== 3'd0) begin
      failures++;
      $display("FAIL areset_after got=v%b s%0d exp=v1 s0", bus.out_valid, bus.out_src);
    end
    bus.in_valid = '0;
    step();
  endtask

`ifdef CHILD_RESPONSE_COLLECTOR_COUNT_EN
  task automatic test_count();
    do_reset();
    checks++;
    if (word_count !== 16'd0) begin failures++; $display("FAIL count_reset got=%0d exp=0", word_count); end
    bus.in_valid  = 5'b00001;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 7; c++) step();
    bus.in_valid = '0;
    step();
    checks++;
    if (word_count !== 16'd7) begin failures++; $display("FAIL count_seven got=%0d exp=7", word_count); end
    force dut.word_count_q = 16'hFFFE;
    step();
    release dut.word_count_q;
    bus.in_valid = 5'b00001;
    for (int c = 0; c < 3; c++) step();
    bus.in_valid = '0;
    step();
    checks++;
    if (word_count !== 16'hFFFF) begin failures++; $display("FAIL count_saturate got=%h exp=FFFF", word_count); end
  endtask
`endif

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    set_pattern_data();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_async_reset();
`ifdef CHILD_RESPONSE_COLLECTOR_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
